// File: rtl/rs_enc_pkg.sv
// rs_enc_pkg: RS(204,188) field constants, GF(2^8) constant multiplier and generator coefficients
package rs_enc_pkg;
    localparam int RS_N = 204;
    localparam int RS_K = 188;
    localparam int RS_NPAR = 16;
    localparam logic [7:0] GF_POLY = 8'h1D;
    typedef logic [RS_NPAR-1:0][7:0] gen_t;
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] r;
        logic [7:0] x;
        r = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            r ^= c[i] ? x : 8'h00;
            x = xtime(x);
        end
        return r;
    endfunction
    // g(x) = prod_{i=0..15} (x + alpha^i); the monic x^16 term is implicit
    function automatic gen_t gen_poly();
        logic [RS_NPAR:0][7:0] g;
        logic [7:0] root;
        g = '0;
        g[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < RS_NPAR; i++) begin
            for (int j = RS_NPAR; j > 0; j--) g[j] = g[j-1] ^ gf_mul_const(g[j], root);
            g[0] = gf_mul_const(g[0], root);
            root = xtime(root);
        end
        return g[RS_NPAR-1:0];
    endfunction
    localparam gen_t G = gen_poly();
endpackage

// File: rtl/rs_enc_if.sv
// rs_enc_if: byte stream into the encoder (CE, input_byte) and codeword stream out (Out_byte, CEO, Valid_out, Par_out, Sob_out)
interface rs_enc_if;
    logic       CE;
    logic [7:0] input_byte;
    logic [7:0] Out_byte;
    logic       CEO;
    logic       Valid_out;
    logic       Par_out;
    logic       Sob_out;
    modport master (output CE, input_byte, input Out_byte, CEO, Valid_out, Par_out, Sob_out);
    modport slave  (input CE, input_byte, output Out_byte, CEO, Valid_out, Par_out, Sob_out);
endinterface

// File: rtl/rs_enc_lfsr.sv
// rs_enc_lfsr: 16x8 parity register bank; ports clk, reset, shift (advance), fb_en (data phase), feed (message byte), p_top (p[15])
module rs_enc_lfsr
    import rs_enc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       shift,
    input  logic       fb_en,
    input  logic [7:0] feed,
    output logic [7:0] p_top
);
    logic [RS_NPAR-1:0][7:0] p_q, p_d;
    logic [7:0] fb;
    // zero feedback turns the division step into a plain shift-out with p[0] <= 0
    always_comb begin
        fb = fb_en ? (feed ^ p_q[RS_NPAR-1]) : 8'h00;
        p_d = p_q;
        if (shift) begin
            p_d[0] = gf_mul_const(fb, G[0]);
            for (int i = 1; i < RS_NPAR; i++) p_d[i] = p_q[i-1] ^ gf_mul_const(fb, G[i]);
        end
    end
    always_ff @(posedge clk) p_q <= reset ? '0 : p_d;
    assign p_top = p_q[RS_NPAR-1];
endmodule

// File: rtl/rs_enc.sv
// rs_enc: systematic RS(204,188) encoder; ports clk, reset (sync, active-high), bus (rs_enc_if slave)
module rs_enc
    import rs_enc_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    rs_enc_if.slave  bus
);
    logic [7:0] cnt_q, cnt_d, out_q, out_d, p_top;
    logic ceo_q, ceo_d, valid_q, valid_d, par_q, par_d, sob_q, sob_d;
    logic data_ph, last;
    assign data_ph = cnt_q < 8'(RS_K);
    assign last = cnt_q == 8'(RS_N - 1);
    always_comb begin
        cnt_d   = bus.CE ? (last ? 8'd0 : cnt_q + 8'd1) : cnt_q;
        out_d   = bus.CE ? (data_ph ? bus.input_byte : p_top) : out_q;
        ceo_d   = bus.CE;
        valid_d = valid_q | bus.CE;
        par_d   = bus.CE ? !data_ph : par_q;
        sob_d   = bus.CE ? cnt_q == 8'd0 : sob_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            out_q   <= '0;
            ceo_q   <= 1'b0;
            valid_q <= 1'b0;
            par_q   <= 1'b0;
            sob_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ceo_q   <= ceo_d;
            valid_q <= valid_d;
            par_q   <= par_d;
            sob_q   <= sob_d;
        end
    end
    rs_enc_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .shift (bus.CE),
        .fb_en (data_ph),
        .feed  (bus.input_byte),
        .p_top (p_top)
    );
    assign bus.Out_byte  = out_q;
    assign bus.CEO       = ceo_q;
    assign bus.Valid_out = valid_q;
    assign bus.Par_out   = par_q;
    assign bus.Sob_out   = sob_q;
endmodule

// File: tb/tb_rs_enc.sv
// tb_rs_enc: directed and random-block checks of rs_enc against a long-division / syndrome model
module tb_rs_enc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    rs_enc_if bus();
    rs_enc dut (.clk(clk), .reset(reset), .bus(bus));
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] gg [17];
    logic [7:0] w [204];
    logic [7:0] c [204];
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h11D << (i - 8);
        return p[7:0];
    endfunction
    task automatic build_g();
        logic [7:0] root;
        for (int j = 0; j < 17; j++) gg[j] = 8'h00;
        gg[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < 16; i++) begin
            for (int j = 16; j > 0; j--) gg[j] = gg[j-1] ^ gm(gg[j], root);
            gg[0] = gm(gg[0], root);
            root = gm(root, 8'h02);
        end
    endtask
    task automatic encode();
        logic [7:0] t [204];
        logic [7:0] coef;
        for (int j = 0; j < 204; j++) t[j] = j < 188 ? w[j] : 8'h00;
        for (int j = 0; j < 188; j++) begin
            coef = t[j];
            for (int k = 1; k <= 16; k++) t[j+k] ^= gm(coef, gg[16-k]);
        end
        for (int k = 0; k < 16; k++) w[188+k] = t[188+k];
    endtask
    function automatic logic [7:0] syn(input int i);
        logic [7:0] a;
        logic [7:0] s;
        a = 8'h01;
        for (int k = 0; k < i; k++) a = gm(a, 8'h02);
        s = 8'h00;
        for (int j = 0; j < 204; j++) s = gm(s, a) ^ c[j];
        return s;
    endfunction
    task automatic cyc(input logic ce, input logic [7:0] b);
        bus.CE = ce;
        bus.input_byte = b;
        @(negedge clk);
    endtask
    task automatic test_reset();
        reset = 1'b1;
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        n_cmp++; if (bus.Out_byte !== 8'h00) begin n_bad++; $display("FAIL reset_out got %h exp 00", bus.Out_byte); end
        n_cmp++; if (bus.CEO !== 1'b0) begin n_bad++; $display("FAIL reset_ceo got %b exp 0", bus.CEO); end
        n_cmp++; if (bus.Valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", bus.Valid_out); end
        n_cmp++; if (bus.Par_out !== 1'b0) begin n_bad++; $display("FAIL reset_par got %b exp 0", bus.Par_out); end
        n_cmp++; if (bus.Sob_out !== 1'b0) begin n_bad++; $display("FAIL reset_sob got %b exp 0", bus.Sob_out); end
    endtask
    task automatic test_ce_with_reset();
        reset = 1'b1;
        cyc(1'b1, 8'hAA);
        reset = 1'b0;
        cyc(1'b0, 8'h00);
        n_cmp++; if (bus.CEO !== 1'b0) begin n_bad++; $display("FAIL cerst_ceo got %b exp 0", bus.CEO); end
        n_cmp++; if (bus.Valid_out !== 1'b0) begin n_bad++; $display("FAIL cerst_valid got %b exp 0", bus.Valid_out); end
        n_cmp++; if (bus.Out_byte !== 8'h00) begin n_bad++; $display("FAIL cerst_out got %h exp 00", bus.Out_byte); end
        cyc(1'b1, 8'h5A);
        n_cmp++; if (bus.CEO !== 1'b1) begin n_bad++; $display("FAIL cerst_first_ceo got %b exp 1", bus.CEO); end
        n_cmp++; if (bus.Sob_out !== 1'b1) begin n_bad++; $display("FAIL cerst_first_sob got %b exp 1", bus.Sob_out); end
        n_cmp++; if (bus.Valid_out !== 1'b1) begin n_bad++; $display("FAIL cerst_first_valid got %b exp 1", bus.Valid_out); end
        n_cmp++; if (bus.Out_byte !== 8'h5A) begin n_bad++; $display("FAIL cerst_first_out got %h exp 5a", bus.Out_byte); end
        cyc(1'b0, 8'h00);
        n_cmp++; if (bus.CEO !== 1'b0) begin n_bad++; $display("FAIL cerst_idle_ceo got %b exp 0", bus.CEO); end
        n_cmp++; if (bus.Out_byte !== 8'h5A) begin n_bad++; $display("FAIL cerst_hold_out got %h exp 5a", bus.Out_byte); end
        reset = 1'b1;
        cyc(1'b0, 8'h00);
        reset = 1'b0;
    endtask
    task automatic test_zero_block();
        for (int i = 0; i < 204; i++) begin
            cyc(1'b1, 8'h00);
            n_cmp++; if (bus.CEO !== 1'b1) begin n_bad++; $display("FAIL zero_ceo[%0d] got %b exp 1", i, bus.CEO); end
            n_cmp++; if (bus.Out_byte !== 8'h00) begin n_bad++; $display("FAIL zero_out[%0d] got %h exp 00", i, bus.Out_byte); end
            n_cmp++; if (bus.Par_out !== (i >= 188)) begin n_bad++; $display("FAIL zero_par[%0d] got %b exp %b", i, bus.Par_out, i >= 188); end
            n_cmp++; if (bus.Sob_out !== (i == 0)) begin n_bad++; $display("FAIL zero_sob[%0d] got %b exp %b", i, bus.Sob_out, i == 0); end
            for (int k = 0; k < 7; k++) begin
                cyc(1'b0, 8'h00);
                n_cmp++; if (bus.CEO !== 1'b0) begin n_bad++; $display("FAIL zero_idle_ceo[%0d] got %b exp 0", i, bus.CEO); end
            end
            n_cmp++; if (bus.Par_out !== (i >= 188)) begin n_bad++; $display("FAIL zero_par_hold[%0d] got %b exp %b", i, bus.Par_out, i >= 188); end
        end
    endtask
    task automatic test_impulse();
        for (int i = 0; i < 188; i++) cyc(1'b1, i == 187 ? 8'h01 : 8'h00);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 8'hFF);
            n_cmp++; if (bus.Out_byte !== gg[15-k]) begin n_bad++; $display("FAIL impulse_par[%0d] got %h exp %h", k, bus.Out_byte, gg[15-k]); end
            n_cmp++; if (bus.Par_out !== 1'b1) begin n_bad++; $display("FAIL impulse_parflag[%0d] got %b exp 1", k, bus.Par_out); end
        end
    endtask
    task automatic run_block(input string tag);
        for (int j = 0; j < 188; j++) w[j] = 8'($urandom_range(0, 255));
        encode();
        for (int i = 0; i < 204; i++) begin
            cyc(1'b1, i < 188 ? w[i] : 8'($urandom_range(0, 255)));
            c[i] = bus.Out_byte;
            n_cmp++; if (bus.Out_byte !== w[i]) begin n_bad++; $display("FAIL %s_byte[%0d] got %h exp %h", tag, i, bus.Out_byte, w[i]); end
            n_cmp++; if (bus.Sob_out !== (i == 0)) begin n_bad++; $display("FAIL %s_sob[%0d] got %b exp %b", tag, i, bus.Sob_out, i == 0); end
            n_cmp++; if (bus.Par_out !== (i >= 188)) begin n_bad++; $display("FAIL %s_par[%0d] got %b exp %b", tag, i, bus.Par_out, i >= 188); end
        end
        for (int s = 0; s < 16; s++) begin
            n_cmp++; if (syn(s) !== 8'h00) begin n_bad++; $display("FAIL %s_syndrome[%0d] got %h exp 00", tag, s, syn(s)); end
        end
    endtask
    task automatic test_back_to_back();
        for (int b = 0; b < 100; b++) run_block("b2b");
        n_cmp++; if (bus.Valid_out !== 1'b1) begin n_bad++; $display("FAIL b2b_valid got %b exp 1", bus.Valid_out); end
    endtask
    task automatic test_reset_mid();
        for (int i = 0; i < 100; i++) cyc(1'b1, 8'($urandom_range(0, 255)));
        reset = 1'b1;
        cyc(1'b0, 8'h00);
        reset = 1'b0;
        n_cmp++; if (bus.Valid_out !== 1'b0) begin n_bad++; $display("FAIL mid_valid got %b exp 0", bus.Valid_out); end
        run_block("mid");
    endtask
    initial begin
        bus.CE = 1'b0;
        bus.input_byte = 8'h00;
        build_g();
        @(negedge clk);
        test_reset();
        test_ce_with_reset();
        test_zero_block();
        test_impulse();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
